// File: rtl/assoc_dcache.sv
// assoc_dcache -- set-associative, write-back, write-allocate data cache.
//
// Each frame holds valid, dirty, tag and BLKWORDS 32-bit words. Replacement
// uses per-set LRU ages (0 = most recent). A halt request flushes every dirty
// frame to memory and then parks the cache in HALT until reset.
//
// Optional feature: define DCACHE_HITCOUNT_EN to keep hit/miss counters. The
// flush then ends by writing (hits - misses) to address 32'h3100.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   dmemREN, dmemWEN     datapath read / write request
//   dmemaddr, dmemstore  datapath byte address / store data
//   halt                 start flush (sampled only in IDLE)
//   dhit, dmemload       request complete this cycle / load data
//   flushed              flush done (HALT state)
//   dREN, dWEN           memory read / write request
//   daddr, dstore        memory word address / write data
//   dload, dwait         memory read data / memory busy
module assoc_dcache #(
  parameter int NSETS    = 8,
  parameter int NWAYS    = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int IDX_W   = $clog2(NSETS);
  localparam int OFFB    = $clog2(BLKWORDS);
  localparam int OFF_W   = (OFFB == 0) ? 1 : OFFB;
  localparam int WAY_W   = (NWAYS == 1) ? 1 : $clog2(NWAYS);
  localparam int TAG_W   = 30 - OFFB - IDX_W;
  // One spare bit so the scan index can reach NFRAMES ("past the last frame").
  localparam int FI_W    = IDX_W + WAY_W + 1;
  localparam int NFRAMES = NSETS * NWAYS;

  typedef enum logic [2:0] {
    IDLE, WB, LOAD, FLUSH_SCAN, FLUSH_WB, WRITE_COUNT, HALT
  } state_t;

  state_t           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [FI_W-1:0]  fidx_q, fidx_d;
  logic [IDX_W-1:0] mset_q, mset_d;
  logic [WAY_W-1:0] mway_q, mway_d;
  logic [TAG_W-1:0] mtag_q, mtag_d;

  logic             valid_q [NSETS][NWAYS];
  logic             dirty_q [NSETS][NWAYS];
  logic [TAG_W-1:0] tag_q   [NSETS][NWAYS];
  logic [WAY_W-1:0] age_q   [NSETS][NWAYS];
  logic [31:0]      data_q  [NSETS][NWAYS][BLKWORDS];

  // Builds a memory word address {tag, set, word, 2'b00}.
  function automatic logic [31:0] mkaddr(input logic [TAG_W-1:0] t,
                                         input logic [IDX_W-1:0] s,
                                         input logic [OFF_W-1:0] o);
    logic [31:0] a;
    a = {t, {(32-TAG_W){1'b0}}} | (32'(s) << (2 + OFFB));
    if (OFFB != 0) a = a | (32'(o) << 2);
    return a;
  endfunction

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             req;
  logic             unused_addr;

  assign req_tag     = dmemaddr[31 -: TAG_W];
  assign req_idx     = dmemaddr[2+OFFB +: IDX_W];
  assign req_off     = (OFFB == 0) ? '0 : dmemaddr[2 +: OFF_W];
  assign req         = dmemREN | dmemWEN;
  assign unused_addr = ^dmemaddr[1:0];

  // Flush index -> (set, way); set is the low bits, way the bits above.
  logic [IDX_W-1:0] fset;
  logic [WAY_W-1:0] fway;
  assign fset = fidx_q[IDX_W-1:0];
  assign fway = (NWAYS == 1) ? '0 : fidx_q[IDX_W +: WAY_W];

  logic last;
  assign last = (cnt_q == OFF_W'(BLKWORDS - 1));

  logic             hit;
  logic [WAY_W-1:0] hway;
  logic [WAY_W-1:0] vway;

  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit  = 1'b1;
        hway = WAY_W'(w);
      end
    end
  end

  // Victim: oldest way, overridden by the lowest-index invalid way if any.
  always_comb begin
    vway = '0;
    for (int w = NWAYS - 1; w >= 0; w--)
      if (age_q[req_idx][w] == WAY_W'(NWAYS - 1)) vway = WAY_W'(w);
    for (int w = NWAYS - 1; w >= 0; w--)
      if (!valid_q[req_idx][w]) vway = WAY_W'(w);
  end

`ifdef DCACHE_HITCOUNT_EN
  logic [31:0] hit_count_q, miss_count_q;
`endif

  logic wr_hit, miss_det, fill_we, fill_last, clr_dirty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fidx_d    = fidx_q;
    mset_d    = mset_q;
    mway_d    = mway_q;
    mtag_d    = mtag_q;
    dhit      = 1'b0;
    dmemload  = '0;
    flushed   = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    wr_hit    = 1'b0;
    miss_det  = 1'b0;
    fill_we   = 1'b0;
    fill_last = 1'b0;
    clr_dirty = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          dhit   = 1'b1;
          wr_hit = dmemWEN;
          if (dmemREN) dmemload = data_q[req_idx][hway][req_off];
        end
        if (halt) begin
          state_d = FLUSH_SCAN;
          fidx_d  = '0;
        end else if (req && !hit) begin
          miss_det = 1'b1;
          mset_d   = req_idx;
          mway_d   = vway;
          mtag_d   = req_tag;
          cnt_d    = '0;
          state_d  = dirty_q[req_idx][vway] ? WB : LOAD;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = mkaddr(tag_q[mset_q][mway_q], mset_q, cnt_q);
        dstore = data_q[mset_q][mway_q][cnt_q];
        if (!dwait) begin
          if (last) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD: begin
        dREN  = 1'b1;
        daddr = mkaddr(mtag_q, mset_q, cnt_q);
        if (!dwait) begin
          fill_we = 1'b1;
          if (last) begin
            fill_last = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH_SCAN: begin
        if (fidx_q == FI_W'(NFRAMES)) begin
`ifdef DCACHE_HITCOUNT_EN
          state_d = WRITE_COUNT;
`else
          state_d = HALT;
`endif
        end else if (dirty_q[fset][fway]) begin
          cnt_d   = '0;
          state_d = FLUSH_WB;
        end else begin
          fidx_d = fidx_q + 1'b1;
        end
      end
      FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = mkaddr(tag_q[fset][fway], fset, cnt_q);
        dstore = data_q[fset][fway][cnt_q];
        if (!dwait) begin
          if (last) begin
            clr_dirty = 1'b1;
            cnt_d     = '0;
            fidx_d    = fidx_q + 1'b1;
            state_d   = FLUSH_SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE_COUNT: begin
`ifdef DCACHE_HITCOUNT_EN
        dWEN   = 1'b1;
        daddr  = 32'h0000_3100;
        dstore = hit_count_q - miss_count_q;
        if (!dwait) state_d = HALT;
`else
        state_d = HALT;
`endif
      end
      HALT: flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fidx_q  <= '0;
      mset_q  <= '0;
      mway_q  <= '0;
      mtag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      mset_q  <= mset_d;
      mway_q  <= mway_d;
      mtag_q  <= mtag_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < NSETS; s++) begin
        for (int w = 0; w < NWAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= WAY_W'(w);
          for (int b = 0; b < BLKWORDS; b++) data_q[s][w][b] <= '0;
        end
      end
    end else begin
      if (wr_hit) begin
        data_q[req_idx][hway][req_off] <= dmemstore;
        dirty_q[req_idx][hway]         <= 1'b1;
      end
      // LRU: hit way becomes youngest, ways younger than it age by one.
      if (dhit) begin
        for (int w = 0; w < NWAYS; w++) begin
          if (WAY_W'(w) == hway)
            age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w] < age_q[req_idx][hway])
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
        end
      end
      if (fill_we) data_q[mset_q][mway_q][cnt_q] <= dload;
      if (fill_last) begin
        valid_q[mset_q][mway_q] <= 1'b1;
        dirty_q[mset_q][mway_q] <= 1'b0;
        tag_q[mset_q][mway_q]   <= mtag_q;
      end
      if (clr_dirty) dirty_q[fset][fway] <= 1'b0;
    end
  end

`ifdef DCACHE_HITCOUNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (dhit)     hit_count_q  <= hit_count_q + 32'd1;
      if (miss_det) miss_count_q <= miss_count_q + 32'd1;
    end
  end
`else
  logic unused_miss;
  assign unused_miss = miss_det;
`endif

endmodule

// File: doc/assoc_dcache.md
ASSOC_DCACHE -- requirements
Module: assoc_dcache

Interface
REQ-001 SHALL have parameter NSETS, default 8: number of sets, power of 2, range 2..64.
REQ-002 SHALL have parameter NWAYS, default 2: ways per set, range 1, 2 or 4.
REQ-003 SHALL have parameter BLKWORDS, default 2: 32-bit words per block, range 1, 2, 4 or 8.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- dmemREN, dmemWEN  in  1 each  datapath read and write request.
- dmemaddr  in  32  byte address, laid out as {tag, idx[log2 NSETS], blkoff[log2 BLKWORDS], 2'b00}.
- dmemstore  in  32  store data.
- halt  in  1  start flush.
- dhit  out  1  request is complete this cycle.
- dmemload  out  32  load data.
- flushed  out  1  flush is done.
- dREN, dWEN  out  1 each  memory read and write request.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dload  in  32  memory read data.
- dwait  in  1  memory busy; a word transfers on any cycle with a request asserted and dwait=0.

Function
REQ-005 SHALL be a write-back, write-allocate cache; each frame SHALL hold valid, dirty, tag and BLKWORDS data words.
REQ-006 SHALL have FSM states IDLE, WB, LOAD, FLUSH_SCAN, FLUSH_WB, WRITE_COUNT and HALT.
REQ-007 In IDLE, dhit SHALL be 1 combinationally when (dmemREN|dmemWEN) and some valid way in set idx has a matching tag. dhit SHALL be 0 in every other state.
REQ-008 On a read hit, dmemload SHALL equal the hit word. Otherwise dmemload SHALL be 0.
REQ-009 On a write hit, the word SHALL be updated and the frame marked dirty at the next edge.
REQ-010 Each hit SHALL update LRU ages:
- Hit way age set to 0.
- Ways whose age was below the hit way's old age incremented by 1.
REQ-011 On an IDLE miss, the victim SHALL be the lowest-index invalid way. If all ways are valid, the victim SHALL be the way with age NWAYS-1.
- Dirty victim: go to WB.
- Clean victim: go to LOAD.
REQ-012 In WB, the FSM SHALL write BLKWORDS words in order with dWEN=1, daddr={victim tag, idx, word counter, 2'b00} and dstore=the data word. On the last transfer it SHALL go to LOAD.
REQ-013 In LOAD, the FSM SHALL read words 0..BLKWORDS-1 with dREN=1 and write each dload into the victim frame.
- On the last transfer: frame valid=1, dirty=0, tag written, go to IDLE.
- The request SHALL then hit on the following cycle.
REQ-014 While dwait=1, the word counter, daddr, dstore and the FSM state SHALL hold.
REQ-015 halt SHALL be sampled only in IDLE and SHALL take priority over a pending request. The FSM SHALL then go to FLUSH_SCAN with the frame index at 0.
REQ-016 FLUSH_SCAN SHALL examine one frame (set=index mod NSETS, way=index/NSETS) per cycle.
- Dirty frame: go to FLUSH_WB.
- Clean frame: increment the index.
- After the last frame: go to WRITE_COUNT.
REQ-017 FLUSH_WB SHALL write back all words of the frame as in REQ-012, clear the frame's dirty bit, increment the index, and return to FLUSH_SCAN.
REQ-018 The 32-bit hit_count SHALL increment on every dhit=1 cycle, and the 32-bit miss_count on every IDLE miss detection. Both SHALL wrap modulo 2^32.
REQ-019 HALT SHALL drive flushed=1 with all memory requests 0, and SHALL be exited only by reset.
REQ-020 Every output not named in a state SHALL be 0 in that state.

Reset
REQ-021 nRST=0 SHALL asynchronously set:
- FSM to IDLE.
- All valid and dirty bits to 0, tags and data to 0.
- Way w age to w.
- Counters and flush index to 0.
- All outputs to 0.
REQ-022 Reset mid-WB, LOAD or FLUSH SHALL abort the transfer without completing it.

Configuration
REQ-023 When DCACHE_HITCOUNT_EN is defined, WRITE_COUNT SHALL write hit_count-miss_count to daddr 32'h3100 (dWEN=1, held until dwait=0) and then go to HALT.
REQ-024 When DCACHE_HITCOUNT_EN is undefined, the counters SHALL be absent and the FSM SHALL go from the last FLUSH_SCAN frame directly to HALT.

Verification
REQ-025 Reset, then read 0x40 with dwait=0 (defaults) -> LOAD reads daddr 0x40 and 0x44; dhit=1 on cycle 3 with dmemload=the word returned for 0x40.
REQ-026 Write 0xDEADBEEF to 0x44 after the fill -> dhit=1 the same cycle; a following read of 0x44 returns 0xDEADBEEF.
REQ-027 Dirty line at 0x44, then reads of 0x84 and 0xC4 (same idx 0) -> 0xC4 evicts the 0x40 line through WB: dWEN to 0x40 then 0x44 with data 0xDEADBEEF, then LOAD of 0xC0/0xC4.
REQ-028 Hold dwait=1 for 5 cycles during LOAD word 0 -> daddr stays 0x40, no state change, dhit=0.
REQ-029 halt with two dirty frames and DCACHE_HITCOUNT_EN defined -> exactly 2*BLKWORDS writebacks, then a write to 0x3100 of hits-misses, then flushed=1 held.
REQ-030 Assert nRST during the second WB word -> all outputs 0 immediately; the next read misses.
